// File: rtl/fighter_anim_sequencer.sv
// Per-fighter animation and move sequencer.
// Drives the sprite renderer's character_state, frame and mirror from
// single-clock enable counters, and classifies attacks as normal, special
// or super from a timed history of direction presses.
module fighter_anim_sequencer #(
    parameter int WALK_DIV   = 25_000_000,
    parameter int ATTACK_DIV = 12_500_000,
    parameter int COMBO_GAP  = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_attack,
    input  logic       is_moving,
    input  logic       in_air,
    output logic [1:0] character_state,
    output logic [1:0] frame,
    output logic       mirror,
    output logic       busy,
    output logic       hit_pulse
);

    localparam int WALK_W = (WALK_DIV > 1) ? $clog2(WALK_DIV) : 1;
    localparam int ATK_W  = (ATTACK_DIV > 1) ? $clog2(ATTACK_DIV) : 1;
    localparam int GAP_W  = $clog2(COMBO_GAP + 1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Oldest entry sits in the top bits, newest in [1:0].
    localparam logic [15:0] SUPER_PAT = {DIR_UP, DIR_DOWN, DIR_UP, DIR_DOWN,
                                         DIR_LEFT, DIR_RIGHT, DIR_LEFT, DIR_RIGHT};
    localparam logic [5:0]  SPECIAL_PAT = {DIR_LEFT, DIR_DOWN, DIR_RIGHT};

    typedef enum logic {
        ST_IDLE,
        ST_ATTACK
    } state_t;

    state_t            state, state_d;
    logic [1:0]        char_d, frame_d;
    logic              mirror_d, busy_d, hit_d;
    logic [WALK_W-1:0] walk_cnt, walk_d;
    logic [ATK_W-1:0]  atk_cnt, atk_d;
    logic [GAP_W-1:0]  gap_cnt;
    logic [15:0]       hist;
    logic [3:0]        hist_cnt;
    logic              dir_valid, launch;
    logic [1:0]        dir_code, attack_kind;

    // Direction decode with up > down > left > right priority, plus attack classification.
    always_comb begin
        dir_valid = btn_up | btn_down | btn_left | btn_right;
        if (btn_up)         dir_code = DIR_UP;
        else if (btn_down)  dir_code = DIR_DOWN;
        else if (btn_left)  dir_code = DIR_LEFT;
        else                dir_code = DIR_RIGHT;

        launch = (state == ST_IDLE) && btn_attack;

        if (hist_cnt == 4'd8 && hist == SUPER_PAT)
            attack_kind = 2'b11;
        else if (hist_cnt >= 4'd3 && hist[5:0] == SPECIAL_PAT)
            attack_kind = 2'b10;
        else
            attack_kind = 2'b01;
    end

    // History payload: shifts in every accepted direction, in either state.
    // NOTE: the payload has no reset; hist_cnt alone says which entries are meaningful.
    always_ff @(posedge clk) begin
        if (dir_valid) hist <= {hist[13:0], dir_code};
    end

    // History count and inter-press gap timer; a long enough gap or a launch empties the history.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_cnt <= 4'd0;
            gap_cnt  <= '0;
        end else if (dir_valid) begin
            gap_cnt <= '0;
            if (launch)                hist_cnt <= 4'd1;
            else if (hist_cnt != 4'd8) hist_cnt <= hist_cnt + 4'd1;
        end else begin
            if (gap_cnt != GAP_W'(COMBO_GAP)) gap_cnt <= gap_cnt + GAP_W'(1);
            if (launch || gap_cnt == GAP_W'(COMBO_GAP - 1)) hist_cnt <= 4'd0;
        end
    end

    // State and output registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            character_state <= 2'b00;
            frame           <= 2'd0;
            mirror          <= 1'b0;
            busy            <= 1'b0;
            hit_pulse       <= 1'b0;
            walk_cnt        <= '0;
            atk_cnt         <= '0;
        end else begin
            state           <= state_d;
            character_state <= char_d;
            frame           <= frame_d;
            mirror          <= mirror_d;
            busy            <= busy_d;
            hit_pulse       <= hit_d;
            walk_cnt        <= walk_d;
            atk_cnt         <= atk_d;
        end
    end

    // Next-state logic: walk cycling and attack launch in IDLE, frame schedule in ATTACK.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch can be inferred.
        state_d  = state;
        char_d   = character_state;
        frame_d  = frame;
        mirror_d = mirror;
        busy_d   = busy;
        hit_d    = 1'b0;
        walk_d   = walk_cnt;
        atk_d    = atk_cnt;

        unique case (state)
            ST_IDLE: begin
                if (btn_attack) begin
                    state_d = ST_ATTACK;
                    char_d  = attack_kind;
                    frame_d = 2'd0;
                    atk_d   = '0;
                    busy_d  = 1'b1;
                    walk_d  = '0;
                end else if (in_air || !is_moving) begin
                    frame_d = 2'd0;
                    walk_d  = '0;
                end else if (walk_cnt == WALK_W'(WALK_DIV - 1)) begin
                    walk_d  = '0;
                    frame_d = (frame == 2'd2) ? 2'd0 : frame + 2'd1;
                end else begin
                    walk_d = walk_cnt + WALK_W'(1);
                end

                // Facing only follows presses while not attacking.
                if (dir_valid && dir_code == DIR_LEFT)       mirror_d = 1'b1;
                else if (dir_valid && dir_code == DIR_RIGHT) mirror_d = 1'b0;
            end

            ST_ATTACK: begin
                if (atk_cnt == ATK_W'(ATTACK_DIV - 1)) begin
                    atk_d = '0;
                    case (frame)
                        2'd0: begin
                            frame_d = 2'd1;
                            hit_d   = 1'b1;
                        end
                        2'd1: frame_d = 2'd2;
                        default: begin
                            state_d = ST_IDLE;
                            char_d  = 2'b00;
                            frame_d = 2'd0;
                            busy_d  = 1'b0;
                            walk_d  = '0;
                        end
                    endcase
                end else begin
                    atk_d = atk_cnt + ATK_W'(1);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_fighter_anim_sequencer.sv
// Scoreboard bench for fighter_anim_sequencer with WALK_DIV=4, ATTACK_DIV=3, COMBO_GAP=20.
// Stimulus pushes hand-computed output snapshots keyed by clock edge; monitors
// compare them, and every hit_pulse, against those queues.
module tb_fighter_anim_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       btn_attack = 1'b0, is_moving = 1'b0, in_air = 1'b0;
    logic [1:0] character_state, frame;
    logic       mirror, busy, hit_pulse;

    fighter_anim_sequencer #(
        .WALK_DIV  (4),
        .ATTACK_DIV(3),
        .COMBO_GAP (20)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_up         (btn_up),
        .btn_down       (btn_down),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .btn_attack     (btn_attack),
        .is_moving      (is_moving),
        .in_air         (in_air),
        .character_state(character_state),
        .frame          (frame),
        .mirror         (mirror),
        .busy           (busy),
        .hit_pulse      (hit_pulse)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge k, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [6:0] v;   // {character_state, frame, mirror, busy, hit_pulse}
    } exp_t;

    exp_t exp_q[$];
    int   hit_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input int t, input logic [1:0] cs, input logic [1:0] fr,
                            input logic mir, input logic bsy, input logic hit);
        exp_t e;
        e.t = t;
        e.v = {cs, fr, mir, bsy, hit};
        exp_q.push_back(e);
    endtask

    // Snapshot monitor: compares whenever the scoreboard has an entry due this edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.t < cyc)
                check($sformatf("snapshot_missed@%0d", e.t), cyc, e.t);
            else
                check($sformatf("outputs@%0d", cyc),
                      int'({character_state, frame, mirror, busy, hit_pulse}), int'(e.v));
        end
    end

    // Hit monitor: every hit_pulse the DUT presents must match the next expected hit cycle.
    always @(negedge clk) begin
        if (hit_pulse) begin
            int exp_t_hit;
            exp_t_hit = (hit_q.size() > 0) ? hit_q.pop_front() : -1;
            check("hit_cycle", cyc, exp_t_hit);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive single-cycle pulses; on return cyc is the edge that sampled them.
    task automatic press(input logic u, input logic d, input logic l, input logic r, input logic a);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_attack = a;
        step(1);
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_attack = 0;
    endtask

    // Expected outputs for an attack sampled at edge n (ATTACK_DIV=3).
    task automatic push_attack_exp(input int n, input logic [1:0] kind, input logic m);
        push_exp(n,     kind, 2'd0, m, 1'b1, 1'b0);
        push_exp(n + 2, kind, 2'd0, m, 1'b1, 1'b0);
        push_exp(n + 3, kind, 2'd1, m, 1'b1, 1'b1);
        push_exp(n + 4, kind, 2'd1, m, 1'b1, 1'b0);
        push_exp(n + 5, kind, 2'd1, m, 1'b1, 1'b0);
        push_exp(n + 6, kind, 2'd2, m, 1'b1, 1'b0);
        push_exp(n + 8, kind, 2'd2, m, 1'b1, 1'b0);
        push_exp(n + 9, 2'b00, 2'd0, m, 1'b0, 1'b0);
        hit_q.push_back(n + 3);
    endtask

    // Launch an attack and run it to completion; returns at edge n+9.
    task automatic run_attack(input logic [1:0] kind, input logic m);
        int n;
        n = cyc + 1;
        push_attack_exp(n, kind, m);
        press(0, 0, 0, 0, 1);
        step(9);
    endtask

    initial begin
        int r, n, l, d;

        // Reset state
        step(3);
        push_exp(cyc, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        push_exp(cyc + 1, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        step(2);

        // Walk: frame advances every 4 edges, drops to 0 when movement stops
        r = cyc;
        push_exp(r + 3,  2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        push_exp(r + 4,  2'b00, 2'd1, 1'b0, 1'b0, 1'b0);
        push_exp(r + 7,  2'b00, 2'd1, 1'b0, 1'b0, 1'b0);
        push_exp(r + 8,  2'b00, 2'd2, 1'b0, 1'b0, 1'b0);
        push_exp(r + 11, 2'b00, 2'd2, 1'b0, 1'b0, 1'b0);
        push_exp(r + 12, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        push_exp(r + 16, 2'b00, 2'd1, 1'b0, 1'b0, 1'b0);
        push_exp(r + 17, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        is_moving = 1'b1;
        step(16);
        is_moving = 1'b0;
        step(1);

        // Airborne while moving: frame held at 0
        r = cyc;
        push_exp(r + 4, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        push_exp(r + 6, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        is_moving = 1'b1;
        in_air    = 1'b1;
        step(6);
        is_moving = 1'b0;
        in_air    = 1'b0;
        step(2);

        // Normal attack, with a second attack press mid-animation ignored
        n = cyc + 1;
        push_attack_exp(n, 2'b01, 1'b0);
        push_exp(n + 10, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        press(0, 0, 0, 0, 1);
        step(4);
        press(0, 0, 0, 0, 1);
        step(5);

        // Special combo: left, down, right five cycles apart
        l = cyc + 1;
        push_exp(l,      2'b00, 2'd0, 1'b1, 1'b0, 1'b0);
        push_exp(l + 9,  2'b00, 2'd0, 1'b1, 1'b0, 1'b0);
        push_exp(l + 10, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        press(0, 0, 1, 0, 0);
        step(4);
        press(0, 1, 0, 0, 0);
        step(4);
        press(0, 0, 0, 1, 0);
        step(4);
        run_attack(2'b10, 1'b0);
        // History was cleared by the launch
        run_attack(2'b01, 1'b0);

        // Super combo
        press(1, 0, 0, 0, 0); press(0, 1, 0, 0, 0); press(1, 0, 0, 0, 0); press(0, 1, 0, 0, 0);
        press(0, 0, 1, 0, 0); press(0, 0, 0, 1, 0); press(0, 0, 1, 0, 0); press(0, 0, 0, 1, 0);
        run_attack(2'b11, 1'b0);

        // Super combo with up+down together on the first step (recorded as up)
        press(1, 1, 0, 0, 0); press(0, 1, 0, 0, 0); press(1, 0, 0, 0, 0); press(0, 1, 0, 0, 0);
        press(0, 0, 1, 0, 0); press(0, 0, 0, 1, 0); press(0, 0, 1, 0, 0); press(0, 0, 0, 1, 0);
        run_attack(2'b11, 1'b0);

        // Gap timeout: 20 idle cycles after down clears the history
        press(0, 0, 1, 0, 0);
        press(0, 1, 0, 0, 0);
        step(20);
        press(0, 0, 0, 1, 0);
        run_attack(2'b01, 1'b0);

        // 19 idle cycles keeps the history
        press(0, 0, 1, 0, 0);
        press(0, 1, 0, 0, 0);
        step(19);
        press(0, 0, 0, 1, 0);
        run_attack(2'b10, 1'b0);

        // Mirror frozen during attack, then reset at attack frame 1
        l = cyc + 1;
        n = l + 1;
        push_exp(l,     2'b00, 2'd0, 1'b1, 1'b0, 1'b0);
        push_exp(n,     2'b01, 2'd0, 1'b1, 1'b1, 1'b0);
        push_exp(n + 1, 2'b01, 2'd0, 1'b1, 1'b1, 1'b0);
        push_exp(n + 2, 2'b01, 2'd0, 1'b1, 1'b1, 1'b0);
        push_exp(n + 3, 2'b01, 2'd1, 1'b1, 1'b1, 1'b1);
        push_exp(n + 4, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        push_exp(n + 6, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        hit_q.push_back(n + 3);
        press(0, 0, 1, 0, 0);
        press(0, 0, 0, 0, 1);
        press(0, 0, 0, 1, 0);
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(2);

        // Let monitors drain, then every expectation must have been consumed
        d = cyc;
        step(3);
        check("snapshots_drained", exp_q.size(), 0);
        check("hits_drained", hit_q.size(), 0);
        check("run_length", cyc - d, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fighter_anim_sequencer.md
# fighter_anim_sequencer

Per-fighter animation and move sequencer that drives the sprite renderer's `character_state`, frame select and `mirror` inputs. It replaces free-running derived clocks with single-clock enable counters. It decodes direction/attack pulses into normal, special and super attacks via a timed combo history. One instance per player sits between the input/game-logic layer and the sprite renderer.

## Interface
- `WALK_DIV`, default 25_000_000: clk cycles per walk frame (2 Hz at 50 MHz).
- `ATTACK_DIV`, default 12_500_000: clk cycles per attack frame (4 Hz).
- `COMBO_GAP`, default 25_000_000: maximum clk cycles between direction presses before the combo history clears.
- `clk` in 1: system clock; sole clock domain.
- `reset` in 1: synchronous, active-high.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: single-cycle press pulses (already debounced/edge-detected).
- `btn_attack` in 1: single-cycle attack press pulse.
- `is_moving` in 1: fighter is moving horizontally (level).
- `in_air` in 1: fighter is airborne (level).
- `character_state` out 2: 00 idle/walk, 01 normal, 10 special, 11 super; registered.
- `frame` out 2: animation frame 0..2 within the current state; registered, never 3.
- `mirror` out 1: facing; 1 = facing left.
- `busy` out 1: high while an attack animation plays.
- `hit_pulse` out 1: one-cycle strobe when an attack enters frame 1 (active frame).

## Operation
- States: IDLE, ATTACK. Attack kind is held in `character_state`.
- Direction encoding: up=0, down=1, left=2, right=3.
- Direction priority for multiple pulses in one cycle: up > down > left > right. Only one direction is recorded per cycle.
- History: 8-entry shift register of 2-bit codes plus a 4-bit valid count saturating at 8. Each accepted direction shifts in as newest. History is recorded in both states.
- Gap counter: reset to 0 on each accepted direction; increments otherwise. On reaching COMBO_GAP, history count is cleared and the counter holds.
- IDLE with `in_air`=1: `frame`=0, walk counter cleared.
- IDLE with `is_moving`=1 and `in_air`=0: walk counter counts 0..WALK_DIV-1. On wrap, `frame` advances 0→1→2→0.
- IDLE with `is_moving`=0: `frame`=0 next cycle, walk counter cleared.
- `btn_attack` in IDLE launches an attack. Classification uses the history as it stood before this cycle, and this cycle's direction is still recorded. Check in this order:
  - Super: the newest 8 entries, oldest first, are up,down,up,down,left,right,left,right with count=8.
  - Special: the newest 3 entries are left,down,right with count≥3.
  - Otherwise normal.
- On launch: history cleared (count=0); `frame`=0; attack counter=0; `busy`=1; `character_state` set to 01, 10 or 11.
- ATTACK: the attack counter counts 0..ATTACK_DIV-1. On wrap, `frame` 0→1 (asserting `hit_pulse` that cycle), 1→2. On wrap from 2: IDLE, `character_state`=00, `frame`=0, `busy`=0, walk counter cleared.
- `btn_attack` during ATTACK is ignored (no queueing).
- `mirror`:
  - Set by an accepted left, cleared by an accepted right, in IDLE only.
  - Frozen during ATTACK.
  - Left/right presses during ATTACK still enter the history but do not change `mirror`.

## Timing
- Reset values: `character_state`=00, `frame`=0, `mirror`=0, `busy`=0, `hit_pulse`=0. All counters and history count are 0, state IDLE.
- Reset asserted mid-attack aborts on the next edge.
- Attack latency: `btn_attack` sampled at edge N gives `character_state`/`busy` valid after edge N, with `frame`=0.
- Frame schedule: `frame`=1 and `hit_pulse` after edge N+ATTACK_DIV; `frame`=2 after N+2·ATTACK_DIV; idle after N+3·ATTACK_DIV. Total busy time is exactly 3·ATTACK_DIV cycles.
- Walk: the first frame advance occurs WALK_DIV cycles after `is_moving` rises.
- Outputs change only on `clk` rising edges. No combinational input→output paths.

## Test plan
Parameters for all scenarios: WALK_DIV=4, ATTACK_DIV=3, COMBO_GAP=20.

- **Reset / walk:** reset, then `is_moving`=1 for 13 cycles → `frame` goes 0,1,2,0 with changes every 4 cycles. `is_moving`=0 → `frame`=0 next cycle. `in_air`=1 while moving → `frame` held 0.
- **Normal attack:** `btn_attack` at cycle 10 → `character_state`=01 and `busy`=1 from cycle 11; `frame`=1 with `hit_pulse` for one cycle at 14; `frame`=2 at 17; `character_state`=00 and `busy`=0 at 20. A second `btn_attack` at cycle 15 has no effect.
- **Special combo:** pulses left, down, right 5 cycles apart, then `btn_attack` → `character_state`=10. An immediate following attack after return to IDLE → 01 (history cleared).
- **Super combo and priority:** up,down,up,down,left,right,left,right then attack → 11. Repeat with up+down in the same cycle at step 1 → recorded as up only, still 11.
- **Gap timeout:** left, down, then wait 20 cycles, right, attack → 01. Same sequence with a 19-cycle gap → 10.
- **Mirror and reset mid-attack:** left → `mirror`=1. During an attack, right → `mirror` stays 1. `reset` at attack frame 1 → all outputs return to reset values on the next edge.
